// File: rtl/slow_tick_bcd_counter_pkg.sv
// Shared types, segment constants and digit arithmetic
// for the slow-tick BCD counter.
package slow_tick_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Returns {digit_out, cout}; cout is carry (up) or borrow (down).
  function automatic logic [4:0] bcd_inc_dec(
    input logic [3:0] digit,
    input logic       down,
    input logic       cin
  );
    logic [4:0] res;
    res = {digit, 1'b0};
    if (cin) begin
      if (!down) begin
        if (digit == 4'd9) res = {4'd0, 1'b1};
        else               res = {digit + 4'd1, 1'b0};
      end else begin
        if (digit == 4'd0) res = {4'd9, 1'b1};
        else               res = {digit - 4'd1, 1'b0};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/slow_tick_bcd_counter_if.sv
// Control and display bundle between the counter
// and whatever drives/consumes it.
interface slow_tick_bcd_counter_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    slow_in;
  logic                    run;
  logic                    clear;
  logic                    down;
  logic                    tick;
  logic                    wrap;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic [7*NUM_DIGITS-1:0] hex;

  modport master (
    output slow_in, run, clear, down,
    input  tick, wrap, bcd, hex
  );

  modport slave (
    input  slow_in, run, clear, down,
    output tick, wrap, bcd, hex
  );
endinterface

// File: rtl/slow_tick_bcd_counter_seg7.sv
// One BCD digit to active-low {g,f,e,d,c,b,a};
// non-decimal codes and blanked digits go dark.
module seg7_decode
  import slow_tick_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  // Digit lookup with blanking override
  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      unique case (i_bcd)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/slow_tick_bcd_counter.sv
// Slow square wave -> clk50 tick -> run/hold/clear
// up/down BCD counter with registered 7-seg output.
module slow_tick_bcd_counter
  import slow_tick_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int BLANK_LZ    = 0
) (
  input logic                   clk50,
  input logic                   rst_n,
  slow_tick_bcd_counter_if.slave bus
);

  localparam int BW = 4 * NUM_DIGITS;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_tick;
  logic                   r_wrap;
  logic [BW-1:0]          r_bcd;
  logic [BW-1:0]          w_bcd_next;
  logic                   w_cout;
  logic [NUM_DIGITS-1:0]  w_blank;
  logic                   w_edge;
  logic                   w_count;
  state_e                 r_state;
  state_e                 w_state_next;

  assign w_edge  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_count = (r_state == RUN) & w_edge & ~bus.clear;

  // Synchronise slow_in, keep previous value, register edge
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.slow_in};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_tick <= w_edge;
    end
  end

  // State register
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state; clear wins over everything
  always_comb begin
    w_state_next = r_state;
    if (bus.clear) begin
      w_state_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (bus.run)  w_state_next = RUN;
        RUN:     if (!bus.run) w_state_next = HOLD;
        HOLD:    if (bus.run)  w_state_next = RUN;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Ripple carry/borrow across digits, one step per tick
  always_comb begin
    logic       c;
    logic [4:0] r;
    w_bcd_next = '0;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r = bcd_inc_dec(r_bcd[4*i +: 4], bus.down, c);
      w_bcd_next[4*i +: 4] = r[4:1];
      c = r[0];
    end
    w_cout = c;
  end

  // Count register and rollover pulse
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd  <= '0;
      r_wrap <= 1'b0;
    end else if (bus.clear) begin
      r_bcd  <= '0;
      r_wrap <= 1'b0;
    end else if (w_count) begin
      r_bcd  <= w_bcd_next;
      r_wrap <= w_cout;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  // Digit i>0 blanks when it and everything above it is zero
  always_comb begin
    logic z;
    w_blank = '0;
    z = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z = z & (r_bcd[4*i +: 4] == 4'd0);
      if (BLANK_LZ != 0 && i != 0) w_blank[i] = z;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    localparam logic [6:0] RST_SEG =
      (g == 0 || BLANK_LZ == 0) ? SEG_0 : SEG_BLANK;

    logic [6:0] w_seg;
    logic [6:0] r_seg;

    seg7_decode u_dec (
      .i_bcd   (r_bcd[4*g +: 4]),
      .i_blank (w_blank[g]),
      .o_seg   (w_seg)
    );

    // Registered display, one cycle behind the count
    always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) r_seg <= RST_SEG;
      else        r_seg <= w_seg;
    end

    assign bus.hex[7*g +: 7] = r_seg;
  end

  assign bus.tick = r_tick;
  assign bus.wrap = r_wrap;
  assign bus.bcd  = r_bcd;

endmodule

// File: tb/tb_slow_tick_bcd_counter.sv
// Scoreboard bench: two counters (BLANK_LZ 0 and 1)
// share stimulus; a monitor checks every tick.
module tb_slow_tick_bcd_counter;

  typedef struct {
    logic [15:0] bcd;
    logic        wrap;
  } exp_t;

  logic clk50 = 1'b0;
  logic rst_n = 1'b0;
  logic slow_in = 1'b0;
  logic run = 1'b0;
  logic clear = 1'b0;
  logic down = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  exp_t q[$];

  slow_tick_bcd_counter_if #(.NUM_DIGITS(4)) bus0 ();
  slow_tick_bcd_counter_if #(.NUM_DIGITS(4)) bus1 ();

  assign bus0.slow_in = slow_in;
  assign bus0.run     = run;
  assign bus0.clear   = clear;
  assign bus0.down    = down;
  assign bus1.slow_in = slow_in;
  assign bus1.run     = run;
  assign bus1.clear   = clear;
  assign bus1.down    = down;

  slow_tick_bcd_counter #(
    .NUM_DIGITS(4), .SYNC_STAGES(2), .BLANK_LZ(0)
  ) dut0 (
    .clk50 (clk50),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  slow_tick_bcd_counter #(
    .NUM_DIGITS(4), .SYNC_STAGES(2), .BLANK_LZ(1)
  ) dut1 (
    .clk50 (clk50),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk50 = ~clk50;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'h7F;
    endcase
  endfunction

  function automatic logic [27:0] enc(input logic [15:0] b,
                                      input bit blz);
    logic z;
    z = 1'b1;
    enc = '0;
    for (int i = 3; i >= 0; i--) begin
      z = z & (b[4*i +: 4] == 4'd0);
      enc[7*i +: 7] = (blz && i != 0 && z) ? 7'h7F
                                           : seg(b[4*i +: 4]);
    end
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    to_bcd = {4'(n / 1000 % 10), 4'(n / 100 % 10),
              4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One slow_in period of 20 cycles; run/clear/down applied
  // in the cycle whose closing edge sees the sync'd edge.
  task automatic pulse(input logic rv, input logic cv,
                       input logic dv, input logic [15:0] eb,
                       input logic ew);
    exp_t e;
    e.bcd = eb;
    e.wrap = ew;
    q.push_back(e);
    @(negedge clk50);
    down = ~dv;
    slow_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk50);
      if (k == 2) begin
        run = rv;
        clear = cv;
        down = dv;
      end
      if (k >= 2 && k <= 4)
        check("tick_timing", 32'(bus0.tick), 32'(k == 3));
      if (k == 10) slow_in = 1'b0;
    end
  endtask

  // Monitor: pop on each tick, check hex/wrap one cycle later
  logic        hex_pend = 1'b0;
  logic [15:0] last_bcd = '0;
  always begin
    exp_t e;
    @(negedge clk50);
    if (hex_pend) begin
      check("hex_lz0", 32'(bus0.hex), 32'(enc(last_bcd, 1'b0)));
      check("hex_lz1", 32'(bus1.hex), 32'(enc(last_bcd, 1'b1)));
      check("wrap_after", 32'(bus0.wrap), 32'd0);
      hex_pend = 1'b0;
    end
    if (rst_n && bus0.tick) begin
      if (q.size() == 0) begin
        check("unexpected_tick", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("bcd0", 32'(bus0.bcd), 32'(e.bcd));
        check("wrap0", 32'(bus0.wrap), 32'(e.wrap));
        check("bcd1", 32'(bus1.bcd), 32'(e.bcd));
        check("wrap1", 32'(bus1.wrap), 32'(e.wrap));
        last_bcd = e.bcd;
        hex_pend = 1'b1;
      end
    end
  end

  task automatic check_reset(input string nm);
    check({nm, "_bcd"}, 32'(bus0.bcd), 32'd0);
    check({nm, "_tick"}, 32'(bus0.tick), 32'd0);
    check({nm, "_wrap"}, 32'(bus0.wrap), 32'd0);
    check({nm, "_hex0"}, 32'(bus0.hex),
          32'({4{7'b1000000}}));
    check({nm, "_hex1"}, 32'(bus1.hex),
          32'({7'h7F, 7'h7F, 7'h7F, 7'b1000000}));
    check({nm, "_bcd1"}, 32'(bus1.bcd), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk50);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk50);
    run = 1'b1;

    pulse(1, 0, 0, 16'h0001, 0);
    pulse(1, 0, 0, 16'h0002, 0);
    pulse(1, 0, 0, 16'h0003, 0);
    check("hex_d0_three", 32'(bus0.hex[6:0]), 32'(7'b0110000));

    for (int n = 4; n <= 9; n++) pulse(1, 0, 0, to_bcd(n), 0);
    pulse(1, 0, 0, 16'h0010, 0);

    pulse(0, 0, 0, 16'h0011, 0);
    pulse(0, 0, 0, 16'h0011, 0);
    pulse(1, 0, 0, 16'h0011, 0);
    pulse(1, 0, 0, 16'h0012, 0);

    for (int n = 13; n <= 42; n++) pulse(1, 0, 0, to_bcd(n), 0);
    pulse(1, 1, 0, 16'h0000, 0);
    @(negedge clk50);
    clear = 1'b0;
    pulse(1, 0, 0, 16'h0001, 0);

    pulse(1, 0, 1, 16'h0000, 0);
    pulse(1, 0, 1, 16'h9999, 1);
    pulse(1, 0, 1, 16'h9998, 0);
    pulse(1, 0, 0, 16'h9999, 0);
    pulse(1, 0, 0, 16'h0000, 1);
    pulse(1, 0, 0, 16'h0001, 0);

    for (int n = 2; n <= 123; n++) pulse(1, 0, 0, to_bcd(n), 0);
    check("pre_reset_bcd", 32'(bus0.bcd), 32'h0123);

    @(posedge clk50);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    rst_n = 1'b1;
    @(negedge clk50);

    for (int n = 1; n <= 7; n++) pulse(1, 0, 0, to_bcd(n), 0);
    check("blank_lz_7", 32'(bus1.hex),
          32'({7'h7F, 7'h7F, 7'h7F, 7'b1111000}));

    repeat (3) @(negedge clk50);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
